datamem_arbiter: RTL

Sequencing arbiter placed in front of the single-ported data memory. It shares the memory between the CPU's load/store port and the accelerator's request stream. CPU requests have priority. Accelerator requests are buffered in a small FIFO, so none are dropped while the CPU holds the port, and a starvation counter forces accelerator service after a bounded wait. Out-of-range accesses are range-checked and suppressed before they reach the memory.

---
 rtl/datamem_arbiter_if.sv | 41 ++++
 rtl/datamem_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the data-memory arbiter and its CPU, accelerator and memory neighbours.
// master = surrounding system (CPU/accel/memory); slave = the arbiter.
interface datamem_arbiter_if;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wrt_data;
  logic         cpu_wrt_en;
  logic         cpu_rd_en;
  logic         cpu_stall;
  logic         cpu_rd_valid;
  logic [31:0]  cpu_rd_data;
  logic         accel_req_valid;
  logic         accel_req_ready;
  logic [15:0]  accel_addr;
  logic [31:0]  accel_wrt_data;
  logic         accel_wrt_en;
  logic         accel_rd_valid;
  logic [511:0] accel_rd_data;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_wrt_data;
  logic         mem_wrt_en;
  logic [511:0] mem_rd_data;
  logic         err;

  modport master (
    output cpu_addr, cpu_wrt_data, cpu_wrt_en, cpu_rd_en,
    output accel_req_valid, accel_addr, accel_wrt_data, accel_wrt_en,
    output mem_rd_data,
    input  cpu_stall, cpu_rd_valid, cpu_rd_data,
    input  accel_req_ready, accel_rd_valid, accel_rd_data,
    input  mem_addr, mem_wrt_data, mem_wrt_en, err
  );

  modport slave (
    input  cpu_addr, cpu_wrt_data, cpu_wrt_en, cpu_rd_en,
    input  accel_req_valid, accel_addr, accel_wrt_data, accel_wrt_en,
    input  mem_rd_data,
    output cpu_stall, cpu_rd_valid, cpu_rd_data,
    output accel_req_ready, accel_rd_valid, accel_rd_data,
    output mem_addr, mem_wrt_data, mem_wrt_en, err
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Shares the single-ported data memory between the CPU (priority) and a FIFO-buffered
// accelerator request stream, with starvation forcing and range suppression.
module datamem_arbiter #(
  parameter int MEM_SIZE     = 65536,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  datamem_arbiter_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_ACC} owner_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_ACC} grant_e;

  logic [15:0]   fifo_addr_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic          fifo_we_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  owner_e        owner_q, owner_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  grant_e        grant;
  logic          cpu_req, acc_req, force_acc, push, pop;
  logic          gnt_we, gnt_re, gnt_bad;
  logic [15:0]   gnt_addr;
  logic [31:0]   gnt_data;

  assign cpu_req             = bus.cpu_rd_en | bus.cpu_wrt_en;
  assign acc_req             = (count_q != '0);
  assign force_acc           = acc_req && (starve_q == SW'(STARVE_LIMIT));
  assign bus.accel_req_ready = (count_q != CW'(FIFO_DEPTH));
  assign push                = bus.accel_req_valid && bus.accel_req_ready;
  assign pop                 = (grant == GNT_ACC);

  // No grant at all while reset is held, so a waiting CPU sees cpu_stall = cpu_req.
  always_comb begin
    grant = GNT_NONE;
    if (rst_n) begin
      if (force_acc || (acc_req && !cpu_req)) grant = GNT_ACC;
      else if (cpu_req)                       grant = GNT_CPU;
    end
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    gnt_we   = 1'b0;
    gnt_re   = 1'b0;
    gnt_bad  = 1'b0;
    case (grant)
      GNT_CPU: begin
        gnt_addr = bus.cpu_addr;
        gnt_data = bus.cpu_wrt_data;
        gnt_we   = bus.cpu_wrt_en;
        gnt_re   = bus.cpu_rd_en;
        gnt_bad  = bus.cpu_rd_en && bus.cpu_wrt_en;
      end
      GNT_ACC: begin
        gnt_addr = fifo_addr_q[rd_ptr_q];
        gnt_data = fifo_data_q[rd_ptr_q];
        gnt_we   = fifo_we_q[rd_ptr_q];
        gnt_re   = !fifo_we_q[rd_ptr_q];
      end
      default: ;
    endcase
    // Writes touch 4 units and reads a 64-unit line, hence the two different limits.
    if (gnt_we && ({16'd0, gnt_addr} >= 32'(MEM_SIZE - 3)))  gnt_bad = 1'b1;
    if (gnt_re && ({16'd0, gnt_addr} >= 32'(MEM_SIZE - 63))) gnt_bad = 1'b1;
  end

  assign bus.mem_addr     = gnt_addr;
  assign bus.mem_wrt_data = gnt_data;
  assign bus.mem_wrt_en   = gnt_we && !gnt_bad;
  assign bus.cpu_stall    = cpu_req && (grant != GNT_CPU);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    starve_d = starve_q;
    if (pop || !acc_req)
      starve_d = '0;
    else if ((grant == GNT_CPU) && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + SW'(1);
    owner_d = OWN_NONE;
    if (gnt_re) owner_d = (grant == GNT_CPU) ? OWN_CPU : OWN_ACC;
    zero_d = gnt_re && gnt_bad;
    err_d  = gnt_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.accel_addr;
      fifo_data_q[wr_ptr_q] <= bus.accel_wrt_data;
      fifo_we_q[wr_ptr_q]   <= bus.accel_wrt_en;
    end
  end

  assign bus.cpu_rd_valid   = (owner_q == OWN_CPU);
  assign bus.cpu_rd_data    = (bus.cpu_rd_valid && !zero_q) ? bus.mem_rd_data[31:0] : '0;
  assign bus.accel_rd_valid = (owner_q == OWN_ACC);
  assign bus.accel_rd_data  = (bus.accel_rd_valid && !zero_q) ? bus.mem_rd_data : '0;
  assign bus.err            = err_q;
endmodule
